// File: rtl/multiword_lacg_add_sequencer.sv
// ---------------------------------------------------------------------------
// multiword_lacg_add_sequencer
//
// Purpose:
//   Word-serial wide add/subtract. A single 16-bit look-ahead-carry adder is
//   time-shared across WORDS slices, LSB slice first. The carry is chained
//   between slices through a carry register. The full-width result and its
//   flags are latched when the last slice finishes. A one-cycle done pulse
//   marks completion.
//
// Ports (top):
//   Clock_In      in   1         rising-edge clock
//   Reset_n_In    in   1         asynchronous, active-low reset
//   Start_In      in   1         operation request, sampled only in IDLE
//   Subtract_In   in   1         1 = A-B, 0 = A+B (sampled with Start_In)
//   Carry_In      in   1         initial carry for add, ignored for subtract
//   Data_A_In     in   16*WORDS  operand A
//   Data_B_In     in   16*WORDS  operand B
//   Busy_Out      out  1         high while slices are being processed
//   Done_Out      out  1         one-cycle pulse when Result_Out updates
//   Result_Out    out  16*WORDS  latched sum / difference
//   Carry_Out     out  1         final carry (subtract: 1 = no borrow)
//   Overflow_Out  out  1         two's-complement overflow of full result
//
// Sub-module lacg_adder16:
//   Enable_In     in   1         drives outputs when 1, high-Z when 0
//   A_In, B_In    in   16        slice operands
//   Carry_In      in   1         slice carry-in
//   Sum_Out       out  16        slice sum (high-Z when disabled)
//   Carry_Out     out  1         slice carry-out (high-Z when disabled)
// ---------------------------------------------------------------------------

module lacg_adder16 (
  input  logic        Enable_In,
  input  logic [15:0] A_In,
  input  logic [15:0] B_In,
  input  logic        Carry_In,
  output logic [15:0] Sum_Out,
  output logic        Carry_Out
);

  logic [15:0] gen;
  logic [15:0] prop;
  logic [3:0]  grpGen;
  logic [3:0]  grpProp;
  logic [4:0]  grpCarry;
  logic [16:0] carry;
  logic [15:0] sumRaw;

  // Two-level look-ahead: bit generate/propagate feed 4-bit group
  // generate/propagate, a second-level unit computes every group carry-in
  // directly from Carry_In, and each group then expands its own bit carries.
  always_comb begin
    gen      = A_In & B_In;
    prop     = A_In ^ B_In;
    grpGen   = '0;
    grpProp  = '0;
    grpCarry = '0;
    carry    = '0;

    for (int g = 0; g < 4; g++) begin
      grpGen[g]  = gen[4*g+3]
                 | (prop[4*g+3] & gen[4*g+2])
                 | (prop[4*g+3] & prop[4*g+2] & gen[4*g+1])
                 | (prop[4*g+3] & prop[4*g+2] & prop[4*g+1] & gen[4*g]);
      grpProp[g] = &prop[4*g +: 4];
    end

    grpCarry[0] = Carry_In;
    grpCarry[1] = grpGen[0] | (grpProp[0] & Carry_In);
    grpCarry[2] = grpGen[1] | (grpProp[1] & grpGen[0])
                | (grpProp[1] & grpProp[0] & Carry_In);
    grpCarry[3] = grpGen[2] | (grpProp[2] & grpGen[1])
                | (grpProp[2] & grpProp[1] & grpGen[0])
                | (grpProp[2] & grpProp[1] & grpProp[0] & Carry_In);
    grpCarry[4] = grpGen[3] | (grpProp[3] & grpGen[2])
                | (grpProp[3] & grpProp[2] & grpGen[1])
                | (grpProp[3] & grpProp[2] & grpProp[1] & grpGen[0])
                | (grpProp[3] & grpProp[2] & grpProp[1] & grpProp[0] & Carry_In);

    for (int g = 0; g < 4; g++) begin
      carry[4*g]   = grpCarry[g];
      carry[4*g+1] = gen[4*g] | (prop[4*g] & grpCarry[g]);
      carry[4*g+2] = gen[4*g+1] | (prop[4*g+1] & gen[4*g])
                   | (prop[4*g+1] & prop[4*g] & grpCarry[g]);
      carry[4*g+3] = gen[4*g+2] | (prop[4*g+2] & gen[4*g+1])
                   | (prop[4*g+2] & prop[4*g+1] & gen[4*g])
                   | (prop[4*g+2] & prop[4*g+1] & prop[4*g] & grpCarry[g]);
    end
    carry[16] = grpCarry[4];

    sumRaw = prop ^ carry[15:0];
  end

  // The adder sits on a shared datapath, so it releases its outputs when
  // not selected.
  assign Sum_Out   = Enable_In ? sumRaw    : 16'bz;
  assign Carry_Out = Enable_In ? carry[16] : 1'bz;

endmodule


module multiword_lacg_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  Clock_In,
  input  logic                  Reset_n_In,
  input  logic                  Start_In,
  input  logic                  Subtract_In,
  input  logic                  Carry_In,
  input  logic [16*WORDS-1:0]   Data_A_In,
  input  logic [16*WORDS-1:0]   Data_B_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic [16*WORDS-1:0]   Result_Out,
  output logic                  Carry_Out,
  output logic                  Overflow_Out
);

  localparam int WIDTH = 16 * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  index_q;
  logic [WIDTH-1:0]  operandA_q;
  logic [WIDTH-1:0]  operandB_q;
  // Only the lower WORDS-1 slices need holding; the top slice goes straight
  // from the adder into the latched result.
  logic [WIDTH-17:0] accum_q;
  logic              carryReg_q;
  logic [WIDTH-1:0]  result_q;
  logic              carryOut_q;
  logic              overflow_q;
  logic              busy_q;
  logic              done_q;

  logic              adderEnable;
  logic [15:0]       sliceA;
  logic [15:0]       sliceB;
  logic [15:0]       adderSum;
  logic              adderCarry;
  logic              lastSlice;
  logic              overflow_d;

  // Enable is decoded from the state register, so the asynchronous reset
  // drops it without waiting for a clock edge.
  assign adderEnable = (state_q == RUN);
  assign lastSlice   = (index_q == LAST_IDX);

  // Select the operand slices addressed by the slice index.
  always_comb begin
    sliceA = '0;
    sliceB = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (index_q == IDX_W'(w)) begin
        sliceA = operandA_q[16*w +: 16];
        sliceB = operandB_q[16*w +: 16];
      end
    end
  end

  lacg_adder16 uAdder (
    .Enable_In (adderEnable),
    .A_In      (sliceA),
    .B_In      (sliceB),
    .Carry_In  (carryReg_q),
    .Sum_Out   (adderSum),
    .Carry_Out (adderCarry)
  );

  // Signed overflow: operands of equal sign giving a result of the other
  // sign. Only meaningful on the top slice, where the sign bits live.
  assign overflow_d = (sliceA[15] == sliceB[15]) && (adderSum[15] != sliceA[15]);

  // Control FSM plus datapath registers. Adder outputs are consumed only in
  // the RUN branch, the one state in which the adder is driving them.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q    <= IDLE;
      index_q    <= '0;
      operandA_q <= '0;
      operandB_q <= '0;
      accum_q    <= '0;
      carryReg_q <= 1'b0;
      result_q   <= '0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start_In) begin
            operandA_q <= Data_A_In;
            // Subtract as A + ~B + 1; the +1 comes in through the carry.
            operandB_q <= Subtract_In ? ~Data_B_In : Data_B_In;
            carryReg_q <= Subtract_In ? 1'b1 : Carry_In;
            index_q    <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end

        RUN: begin
          for (int w = 0; w < WORDS - 1; w++) begin
            if (index_q == IDX_W'(w)) begin
              accum_q[16*w +: 16] <= adderSum;
            end
          end
          carryReg_q <= adderCarry;
          if (lastSlice) begin
            result_q   <= {adderSum, accum_q};
            carryOut_q <= adderCarry;
            overflow_q <= overflow_d;
            index_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            index_q <= index_q + 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy_Out     = busy_q;
  assign Done_Out     = done_q;
  assign Result_Out   = result_q;
  assign Carry_Out    = carryOut_q;
  assign Overflow_Out = overflow_q;

endmodule
